// File: rtl/add32_sequencer.sv
// 32-bit adder sequencer: splits each addition into two passes through an external
// 16-bit ripple-carry adder (low half, then high half). Optional ovf output: ADD32_SEQ_OVF_EN.
module add32_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_s,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        cout,
`ifdef ADD32_SEQ_OVF_EN
    output logic        ovf,
`endif
    output logic [1:0]  dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // valid never depends combinationally on ready, and results hold while out_valid waits.
    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic        c_q, c_d;
    logic [31:0] sum_q, sum_d;
    logic        cout_q, cout_d;
`ifdef ADD32_SEQ_OVF_EN
    logic        ovf_q, ovf_d;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        c_d       = c_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef ADD32_SEQ_OVF_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 16'h0000;
        add_b     = 16'h0000;
        add_cin   = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cin_d   = cin;
                    state_d = LO;
                end
            end
            LO: begin
                add_a        = a_q[15:0];
                add_b        = b_q[15:0];
                add_cin      = cin_q;
                sum_d[15:0]  = add_s;
                c_d          = add_cout;
                state_d      = HI;
            end
            HI: begin
                add_a        = a_q[31:16];
                add_b        = b_q[31:16];
                add_cin      = c_q;
                sum_d[31:16] = add_s;
                cout_d       = add_cout;
`ifdef ADD32_SEQ_OVF_EN
                // Signed overflow: operands agree in sign but the result sign differs.
                ovf_d        = (a_q[31] == b_q[31]) && (add_s[15] != a_q[31]);
`endif
                state_d      = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            cin_q   <= 1'b0;
            c_q     <= 1'b0;
            sum_q   <= 32'h0;
            cout_q  <= 1'b0;
`ifdef ADD32_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef ADD32_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum         = sum_q;
    assign cout        = cout_q;
`ifdef ADD32_SEQ_OVF_EN
    assign ovf         = ovf_q;
`endif
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_add32_sequencer.sv
// Bench for add32_sequencer: behavioural 16-bit adder, scoreboard of expected results,
// directed corner cases plus random traffic with random back-pressure.
module tb_add32_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        cin;
    logic [15:0] add_a, add_b;
    logic        add_cin;
    logic [15:0] add_s;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef ADD32_SEQ_OVF_EN
    logic        ovf;
`endif
    logic [1:0]  dbg_state;

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    logic [33:0] exp_q[$];
    int          pop_cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External 16-bit adder model.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'h0, add_cin};

    add32_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout),
`ifdef ADD32_SEQ_OVF_EN
        .ovf(ovf),
`endif
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: {ovf, cout, sum}
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [32:0] s;
        s = {1'b0, x} + {1'b0, y} + {32'h0, c};
        return {((x[31] == y[31]) && (s[31] != x[31])), s};
    endfunction

    // Scoreboard: compare every completed output handshake against the queue head.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                pop_cyc_q.push_back(cyc);
                check("sum", sum, e[31:0]);
                check("cout", cout, e[32]);
`ifdef ADD32_SEQ_OVF_EN
                check("ovf", ovf, e[33]);
`endif
            end
        end
    end

    // Offer one operand pair; optionally log it on the scoreboard. Returns #1 after the acceptance edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c, input bit push);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; a = x; b = y; cin = c;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        if (push) exp_q.push_back(model(x, y, c));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        logic [31:0] held_sum;
        logic        held_cout;
        int          n;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_add_bus", {add_a, add_b, add_cin}, 0);
        check("rst_state", dbg_state, 0);

        // Low-half carry propagating into the high half
        send(32'h0000FFFF, 32'h00000001, 1'b0, 1);
        @(negedge clk);
        check("lo_add_a", add_a, 16'hFFFF);
        check("lo_add_b", add_b, 16'h0001);
        check("lo_add_cout", add_cout, 1);
        check("lo_in_ready", in_ready, 0);
        @(negedge clk);
        check("hi_add_cin", add_cin, 1);
        check("hi_add_ab", {add_a, add_b}, 0);
        @(negedge clk);
        check("done_valid", out_valid, 1);
        check("done_add_bus", {add_a, add_b, add_cin}, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        drain();

        // Full carry chain and latency (third edge counting the acceptance edge)
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("latency_edges", n, 3);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        drain();

        // Back-pressure in DONE: outputs hold, new input ignored
        send(32'h12345678, 32'h9ABCDEF0, 1'b1, 1);
        repeat (3) @(negedge clk);
        held_sum  = sum;
        held_cout = cout;
        @(posedge clk); #1;
        in_valid = 1'b1; a = 32'h11111111; b = 32'h22222222;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, held_sum);
            check("hold_cout", cout, held_cout);
            check("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("no_ghost_txn", dbg_state, 0);

        // Reset while in HI discards the transaction
        send(32'h00050005, 32'h00060006, 1'b0, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("rst_hi_out_valid", out_valid, 0);
        check("rst_hi_sum", sum, 0);
        check("rst_hi_cout", cout, 0);
        check("rst_hi_in_ready", in_ready, 1);
        repeat (5) @(negedge clk);
        check("rst_hi_idle", dbg_state, 0);

        // Back-to-back with in_valid and out_ready high: pulses 4 cycles apart
        pop_cyc_q.delete();
        send(32'd1, 32'd2, 1'b0, 1);
        send(32'd3, 32'd4, 1'b0, 1);
        drain();
        if (pop_cyc_q.size() == 2) check("throughput_gap", pop_cyc_q[1] - pop_cyc_q[0], 4);
        else check("throughput_pops", pop_cyc_q.size(), 2);
        out_ready = 1'b0;

        // Signed overflow corners
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        drain();
        #1 out_ready = 1'b0;
        send(32'h80000000, 32'h80000000, 1'b0, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        drain();

        // Random traffic with random back-pressure
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send($urandom, $urandom, 1'($urandom_range(0, 1)), 1);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    @(posedge clk); #2 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
